// File: rtl/regfile_dump.sv
// Walks an inclusive register index range, reads each register through an
// external combinational read port and streams it out with a valid/ready handshake.
module regfile_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ctrl_readReg,
  input  logic [DATA_WIDTH-1:0] data_readReg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_reg,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t                stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] curReg, curNext;
  logic [ADDR_WIDTH-1:0] lastReg, lastNext;
  logic [ADDR_WIDTH-1:0] outIdxReg, outIdxNext;
  logic [DATA_WIDTH-1:0] outDataReg, outDataNext;
  logic                  outLastReg, outLastNext;
  logic                  rangeErrReg, rangeErrNext;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      stateReg    <= IDLE;
      curReg      <= '0;
      lastReg     <= '0;
      outIdxReg   <= '0;
      outDataReg  <= '0;
      outLastReg  <= 1'b0;
      rangeErrReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      curReg      <= curNext;
      lastReg     <= lastNext;
      outIdxReg   <= outIdxNext;
      outDataReg  <= outDataNext;
      outLastReg  <= outLastNext;
      rangeErrReg <= rangeErrNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    curNext      = curReg;
    lastNext     = lastReg;
    outIdxNext   = outIdxReg;
    outDataNext  = outDataReg;
    outLastNext  = outLastReg;
    rangeErrNext = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            curNext   = first_reg;
            lastNext  = last_reg;
            stateNext = FETCH;
          end else begin
            rangeErrNext = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          stateNext = IDLE;
        end else begin
          outDataNext = data_readReg;
          outIdxNext  = curReg;
          outLastNext = (curReg == lastReg);
          stateNext   = SEND;
        end
      end
      SEND: begin
        // abort takes priority over a simultaneous handshake
        if (abort) begin
          stateNext = IDLE;
        end else if (out_ready) begin
          if (outLastReg) begin
            stateNext = DONE;
          end else begin
            curNext   = curReg + 1'b1;
            stateNext = FETCH;
          end
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign ctrl_readReg = (stateReg == FETCH) ? curReg : '0;
  assign out_valid    = (stateReg == SEND);
  assign out_reg      = outIdxReg;
  assign out_data     = outDataReg;
  assign out_last     = outLastReg;
  assign busy         = (stateReg != IDLE);
  assign done         = (stateReg == DONE);
  assign range_err    = rangeErrReg;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized and directed bench for regfile_dump; expected words come from
// an index list built from the requested range and a behavioural register array.
module tb_regfile_dump;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        abort;
  logic [4:0]  ctrl_readReg;
  logic [31:0] data_readReg;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        range_err;

  logic [31:0] regs [32];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign data_readReg = regs[ctrl_readReg];

  regfile_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .start(start),
    .first_reg(first_reg), .last_reg(last_reg), .abort(abort),
    .ctrl_readReg(ctrl_readReg), .data_readReg(data_readReg),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .range_err(range_err)
  );

  task automatic checkVal(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_valid"}, out_valid, 0);
    checkVal({tag, "_reg"}, out_reg, 0);
    checkVal({tag, "_data"}, out_data, 0);
    checkVal({tag, "_last"}, out_last, 0);
    checkVal({tag, "_busy"}, busy, 0);
    checkVal({tag, "_done"}, done, 0);
    checkVal({tag, "_rerr"}, range_err, 0);
    checkVal({tag, "_rdidx"}, ctrl_readReg, 0);
  endtask

  // One dump request; a word k is expected to appear 2 + k*(2+stall) cycles after start.
  task automatic runDump(input int f, input int l, input int stall, input int abortAt,
                         input int resetAt, input bit midStart, input bit idleAbort);
    int q[$];
    int cycles, held, k;
    for (int i = f; i <= l; i++) q.push_back(i);
    @(negedge clock);
    start = 1'b1; first_reg = f[4:0]; last_reg = l[4:0]; abort = idleAbort;
    if (f > l) begin
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
      checkVal("rerrPulse", range_err, 1);
      checkVal("rerrBusy", busy, 0);
      checkVal("rerrValid", out_valid, 0);
      @(negedge clock);
      checkVal("rerrEnd", range_err, 0);
      checkVal("rerrBusy2", busy, 0);
      checkVal("rerrValid2", out_valid, 0);
      $display("dump %0d..%0d rejected with range_err", f, l);
      return;
    end
    cycles = 0; held = 0; k = 0;
    while (q.size() > 0) begin
      @(negedge clock);
      cycles++;
      abort = 1'b0;
      start = midStart && (cycles == 3);
      if (start) begin first_reg = 5'd0; last_reg = 5'd31; end
      if (cycles > 400) begin
        checkVal("timeout", cycles, 0);
        out_ready = 1'b0;
        return;
      end
      if (out_valid) begin
        if (held == 0) checkVal("latency", cycles, 2 + k * (2 + stall));
        checkVal("outReg", out_reg, q[0]);
        checkVal("outData", out_data, regs[q[0]]);
        checkVal("outLast", out_last, (q[0] == l) ? 1 : 0);
        checkVal("sendBusy", busy, 1);
        checkVal("sendRdIdx", ctrl_readReg, 0);
        checkVal("sendDone", done, 0);
        if (q[0] == abortAt) begin
          abort = 1'b1; out_ready = 1'b1;
          @(negedge clock);
          abort = 1'b0; out_ready = 1'b0;
          checkVal("abortValid", out_valid, 0);
          checkVal("abortBusy", busy, 0);
          checkVal("abortDone", done, 0);
          repeat (3) begin
            @(negedge clock);
            checkVal("abortNoDone", done, 0);
          end
          $display("dump %0d..%0d aborted at reg %0d", f, l, abortAt);
          return;
        end
        if (q[0] == resetAt) begin
          #2 ctrl_reset = 1'b0;
          #1 checkAllZero("asyncRst");
          @(negedge clock);
          checkVal("rstHeldBusy", busy, 0);
          ctrl_reset = 1'b1; out_ready = 1'b0;
          $display("dump %0d..%0d reset at reg %0d", f, l, resetAt);
          return;
        end
        if (held >= stall) begin
          out_ready = 1'b1;
          void'(q.pop_front());
          held = 0;
          k++;
        end else begin
          out_ready = 1'b0;
          held++;
        end
      end else begin
        // ready raised ahead of valid must not count as a transfer
        out_ready = 1'($urandom_range(0, 1));
        checkVal("fetchIdx", ctrl_readReg, q[0]);
        checkVal("fetchBusy", busy, 1);
      end
    end
    @(negedge clock);
    out_ready = 1'b0;
    checkVal("donePulse", done, 1);
    checkVal("doneValid", out_valid, 0);
    checkVal("doneBusy", busy, 1);
    @(negedge clock);
    checkVal("doneEnd", done, 0);
    checkVal("idleBusy", busy, 0);
    checkVal("noRerr", range_err, 0);
    $display("dump %0d..%0d stall=%0d: %0d words", f, l, stall, k);
  endtask

  initial begin
    ctrl_reset = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0;
    abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    repeat (2) @(negedge clock);
    checkAllZero("reset");
    ctrl_reset = 1'b1;

    runDump(0, 31, 0, -1, -1, 1'b0, 1'b0);
    runDump(5, 5, 0, -1, -1, 1'b0, 1'b0);
    runDump(9, 4, 0, -1, -1, 1'b0, 1'b0);
    runDump(2, 4, 4, -1, -1, 1'b1, 1'b0);
    runDump(0, 31, 0, 10, -1, 1'b0, 1'b0);
    runDump(1, 2, 0, -1, -1, 1'b0, 1'b0);
    runDump(0, 31, 0, -1, 7, 1'b0, 1'b0);
    runDump(0, 1, 0, -1, -1, 1'b0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      int f, l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      runDump(f, l, $urandom_range(0, 2), -1, -1, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
